// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: Moore sequencing FSM, data-processing decode,
// NZCV flag register and condition evaluation for a shared-memory datapath.
module arm_multicycle_controller #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB  = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  flags;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [2:0]  alu_op;
    logic        dp_ok, is_cmp, cv_upd, cond_ex;
    logic        pc_write, mem_write, reg_write, ir_write;
    logic        n_f, z_f, c_f, v_f;
    logic        unused_rn;

    // Instr carries IR[31:12]; IR[19:16] (Rn) is not needed by the controller.
    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        alu_op = 3'b000;
        dp_ok  = 1'b1;
        is_cmp = 1'b0;
        cv_upd = 1'b0;
        case (funct[4:1])
            4'b0100: cv_upd = 1'b1;
            4'b0010: begin alu_op = 3'b001; cv_upd = 1'b1; end
            4'b0000: alu_op = 3'b010;
            4'b1100: alu_op = 3'b011;
            4'b1010: begin alu_op = 3'b001; cv_upd = 1'b1; is_cmp = 1'b1; end
            default: dp_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !(c_f && !z_f);
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = !(!z_f && (n_f == v_f));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            flags <= FLAG_RESET;
        end else begin
            state <= state_nx;
            // CondEx above sees the pre-update flags, so a flag-setting op tests its own cond first.
            if ((state == EXECR || state == EXECI) && funct[0] && cond_ex && dp_ok) begin
                flags[3:2] <= ALUFlags[3:2];
                if (cv_upd) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_nx   = FETCH;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        ir_write   = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        case (state)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_nx  = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_nx = funct[5] ? EXECI : EXECR;
                    2'b01:   state_nx = MEMADR;
                    2'b10:   state_nx = BRANCH;
                    default: state_nx = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB  = 2'b01;
                state_nx = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc   = 1'b1;
                state_nx = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = cond_ex;
                pc_write  = cond_ex && (rd == 4'd15);
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = cond_ex;
                RegSrc    = 2'b10;
            end
            EXECR: begin
                ALUControl = alu_op;
                state_nx   = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
                state_nx   = ALUWB;
            end
            ALUWB: begin
                reg_write = cond_ex && dp_ok && !is_cmp;
                pc_write  = cond_ex && dp_ok && !is_cmp && (rd == 4'd15);
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                RegSrc    = 2'b01;
                pc_write  = cond_ex;
            end
            default: state_nx = FETCH;
        endcase
    end

    // Enables are held off combinationally while reset is asserted, even though the state reads FETCH.
    assign PCWrite  = pc_write  && reset;
    assign MemWrite = mem_write && reset;
    assign RegWrite = reg_write && reset;
    assign IRWrite  = ir_write  && reset;
    assign ImmSrc   = op;
    assign State    = state;
endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed-vector bench for arm_multicycle_controller; flags are observed through conditional branches.
module tb_arm_multicycle_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    typedef struct packed {
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] regsrc, srca, srcb, res, imm;
        logic [2:0] ctl;
        logic [3:0] st;
    } obs_t;

    obs_t cap [0:7];
    int   nvec = 0;
    int   nerr = 0;

    arm_multicycle_controller #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    // Applies one instruction for n cycles starting at a falling edge in FETCH, recording outputs per cycle.
    task automatic run(input logic [19:0] ins, input logic [3:0] af, input int n);
        Instr    = ins;
        ALUFlags = af;
        for (int i = 0; i < n; i++) begin
            cap[i] = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ImmSrc, ALUControl, State};
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0;
        repeat (2) @(negedge clk);
        nvec++; if (State !== 4'd0) begin nerr++; $display("FAIL reset_state got %0d exp 0", State); end
        nvec++; if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            nerr++; $display("FAIL reset_enables got %b exp 0000", {PCWrite, MemWrite, RegWrite, IRWrite}); end
        reset = 1'b1; #1;
        nvec++; if ({State, IRWrite, PCWrite} !== {4'd0, 2'b11}) begin
            nerr++; $display("FAIL release_fetch got st=%0d ir=%b pc=%b exp 0 1 1", State, IRWrite, PCWrite); end
    endtask

    task automatic test_adds;
        obs_t e [0:3];
        e[0] = '{pcw:1, mw:0, rw:0, irw:1, adr:0, regsrc:0, srca:1, srcb:2, res:2, imm:0, ctl:0, st:0};
        e[1] = '{pcw:0, mw:0, rw:0, irw:0, adr:0, regsrc:0, srca:1, srcb:2, res:2, imm:0, ctl:0, st:1};
        e[2] = '{pcw:0, mw:0, rw:0, irw:0, adr:0, regsrc:0, srca:0, srcb:1, res:0, imm:0, ctl:0, st:7};
        e[3] = '{pcw:0, mw:0, rw:1, irw:0, adr:0, regsrc:0, srca:0, srcb:0, res:0, imm:0, ctl:0, st:8};
        run(20'hE2921, 4'b0100, 4);
        for (int i = 0; i < 4; i++) begin
            nvec++; if (cap[i] !== e[i]) begin nerr++; $display("FAIL adds_cyc%0d got %h exp %h", i, cap[i], e[i]); end
        end
        nvec++; if (State !== 4'd0) begin nerr++; $display("FAIL adds_retire got %0d exp 0", State); end
    endtask

    task automatic test_branch;
        obs_t eb;
        eb = '{pcw:1, mw:0, rw:0, irw:0, adr:0, regsrc:1, srca:2, srcb:1, res:2, imm:2, ctl:0, st:9};
        run(20'h0A000, 4'b0000, 3);  // BEQ after ADDS that set Z
        nvec++; if (cap[1].st !== 4'd1 || cap[1].imm !== 2'b10) begin
            nerr++; $display("FAIL beq_decode got st=%0d imm=%0d exp 1 2", cap[1].st, cap[1].imm); end
        nvec++; if (cap[2] !== eb) begin nerr++; $display("FAIL beq_taken got %h exp %h", cap[2], eb); end
        run(20'hE1500, 4'b0000, 4);  // CMP clearing Z
        nvec++; if (cap[2].st !== 4'd6 || cap[2].ctl !== 3'b001 || cap[2].srcb !== 2'b00) begin
            nerr++; $display("FAIL cmp_execr got st=%0d ctl=%0d srcb=%0d exp 6 1 0", cap[2].st, cap[2].ctl, cap[2].srcb); end
        nvec++; if (cap[3].st !== 4'd8 || cap[3].rw !== 1'b0 || cap[3].pcw !== 1'b0) begin
            nerr++; $display("FAIL cmp_aluwb got st=%0d rw=%b pcw=%b exp 8 0 0", cap[3].st, cap[3].rw, cap[3].pcw); end
        run(20'h0A000, 4'b0000, 3);
        nvec++; if (cap[2].st !== 4'd9 || cap[2].pcw !== 1'b0) begin
            nerr++; $display("FAIL beq_not_taken got st=%0d pcw=%b exp 9 0", cap[2].st, cap[2].pcw); end
        run(20'hE1500, 4'b0100, 4);  // CMP setting Z
        run(20'h0A000, 4'b0000, 3);
        nvec++; if (cap[2].pcw !== 1'b1) begin nerr++; $display("FAIL beq_after_cmp got pcw=%b exp 1", cap[2].pcw); end
    endtask

    task automatic test_ldr;
        logic [19:0] seq;
        seq = 20'h43210;
        run(20'hE5903, 4'b0000, 5);
        for (int i = 0; i < 5; i++) begin
            nvec++; if (cap[i].st !== seq[4*i +: 4]) begin
                nerr++; $display("FAIL ldr_state%0d got %0d exp %0d", i, cap[i].st, seq[4*i +: 4]); end
        end
        nvec++; if ({cap[2].srca, cap[2].srcb, cap[2].imm, cap[2].ctl} !== {2'b00, 2'b01, 2'b01, 3'b000}) begin
            nerr++; $display("FAIL ldr_memadr got %h", {cap[2].srca, cap[2].srcb, cap[2].imm, cap[2].ctl}); end
        nvec++; if (cap[3].adr !== 1'b1 || cap[3].rw !== 1'b0) begin
            nerr++; $display("FAIL ldr_memrd got adr=%b rw=%b exp 1 0", cap[3].adr, cap[3].rw); end
        nvec++; if ({cap[4].res, cap[4].rw, cap[4].pcw} !== {2'b01, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL ldr_memwb got res=%0d rw=%b pcw=%b exp 1 1 0", cap[4].res, cap[4].rw, cap[4].pcw); end
    endtask

    task automatic test_strne;
        logic [15:0] seq;
        seq = 16'h5210;
        run(20'hE1500, 4'b0100, 4);  // Z=1 so NE fails
        run(20'h15801, 4'b0000, 4);
        for (int i = 0; i < 4; i++) begin
            nvec++; if (cap[i].st !== seq[4*i +: 4] || cap[i].mw !== 1'b0) begin
                nerr++; $display("FAIL strne_cyc%0d got st=%0d mw=%b exp %0d 0", i, cap[i].st, cap[i].mw, seq[4*i +: 4]); end
        end
        nvec++; if (cap[3].adr !== 1'b1 || cap[3].regsrc !== 2'b10) begin
            nerr++; $display("FAIL strne_memwr got adr=%b regsrc=%0d exp 1 2", cap[3].adr, cap[3].regsrc); end
    endtask

    task automatic test_flags_cv;
        run(20'hE2921, 4'b0010, 4);  // ADDS: C=1
        run(20'hE0100, 4'b1000, 4);  // ANDS: N=1, C kept
        nvec++; if (cap[2].ctl !== 3'b010) begin nerr++; $display("FAIL ands_ctl got %0d exp 2", cap[2].ctl); end
        run(20'hE0300, 4'b0100, 4);  // EOR (unsupported): no flag update, no write
        nvec++; if (cap[3].rw !== 1'b0) begin nerr++; $display("FAIL undef_dp_rw got %b exp 0", cap[3].rw); end
        run(20'h2A000, 4'b0000, 3);  // BCS
        nvec++; if (cap[2].pcw !== 1'b1) begin nerr++; $display("FAIL bcs got pcw=%b exp 1", cap[2].pcw); end
        run(20'h4A000, 4'b0000, 3);  // BMI
        nvec++; if (cap[2].pcw !== 1'b1) begin nerr++; $display("FAIL bmi got pcw=%b exp 1", cap[2].pcw); end
        run(20'h0A000, 4'b0000, 3);  // BEQ, Z must still be 0
        nvec++; if (cap[2].pcw !== 1'b0) begin nerr++; $display("FAIL beq_z0 got pcw=%b exp 0", cap[2].pcw); end
        run(20'hAA000, 4'b0000, 3);  // BGE: N=1 V=0 -> false
        nvec++; if (cap[2].pcw !== 1'b0) begin nerr++; $display("FAIL bge got pcw=%b exp 0", cap[2].pcw); end
        run(20'hE1800, 4'b0000, 4);  // ORR
        nvec++; if (cap[2].st !== 4'd6 || cap[2].ctl !== 3'b011 || cap[3].rw !== 1'b1) begin
            nerr++; $display("FAIL orr got st=%0d ctl=%0d rw=%b exp 6 3 1", cap[2].st, cap[2].ctl, cap[3].rw); end
    endtask

    task automatic test_pc_write;
        run(20'hE080F, 4'b0000, 4);
        nvec++; if ({cap[2].st, cap[3].st, cap[3].rw, cap[3].pcw} !== {4'd6, 4'd8, 1'b1, 1'b1}) begin
            nerr++; $display("FAIL add_pc got st=%0d,%0d rw=%b pcw=%b exp 6,8 1 1", cap[2].st, cap[3].st, cap[3].rw, cap[3].pcw); end
    endtask

    task automatic test_undef;
        run(20'hEC000, 4'b0000, 2);
        nvec++; if ({cap[1].st, cap[1].pcw, cap[1].mw, cap[1].rw, cap[1].irw} !== {4'd1, 4'b0000}) begin
            nerr++; $display("FAIL undef_decode got %h", {cap[1].st, cap[1].pcw, cap[1].mw, cap[1].rw, cap[1].irw}); end
        nvec++; if (State !== 4'd0 || IRWrite !== 1'b1) begin
            nerr++; $display("FAIL undef_retire got st=%0d ir=%b exp 0 1", State, IRWrite); end
    endtask

    task automatic test_reset_mid;
        run(20'hE1500, 4'b0100, 4);  // leave Z=1 before reset
        run(20'hE5801, 4'b0000, 3);  // STR, now sitting in MEMWR
        nvec++; if (State !== 4'd5 || MemWrite !== 1'b1) begin
            nerr++; $display("FAIL str_memwr got st=%0d mw=%b exp 5 1", State, MemWrite); end
        reset = 1'b0; #1;
        nvec++; if (State !== 4'd0 || MemWrite !== 1'b0) begin
            nerr++; $display("FAIL mid_reset got st=%0d mw=%b exp 0 0", State, MemWrite); end
        @(negedge clk);
        nvec++; if ({State, IRWrite, PCWrite} !== {4'd0, 2'b00}) begin
            nerr++; $display("FAIL held_reset got st=%0d ir=%b pc=%b exp 0 0 0", State, IRWrite, PCWrite); end
        reset = 1'b1; #1;
        nvec++; if ({State, IRWrite, PCWrite} !== {4'd0, 2'b11}) begin
            nerr++; $display("FAIL mid_release got st=%0d ir=%b pc=%b exp 0 1 1", State, IRWrite, PCWrite); end
        run(20'h0A000, 4'b0000, 3);  // Flags cleared by reset -> BEQ not taken
        nvec++; if (cap[2].st !== 4'd9 || cap[2].pcw !== 1'b0) begin
            nerr++; $display("FAIL flags_after_reset got st=%0d pcw=%b exp 9 0", cap[2].st, cap[2].pcw); end
    endtask

    initial begin
        test_reset();
        test_adds();
        test_branch();
        test_ldr();
        test_strne();
        test_flags_cv();
        test_pc_write();
        test_undef();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
